dm_cache_main_mem: RTL and testbench

//  Backing-store model and controller that sits directly downstream of the direct-mapped cache FSM.

---
 rtl/dm_cache_main_mem.sv | 194 +++++++++++++++++++
 tb/tb_dm_cache_main_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_main_mem.sv
// -----------------------------------------------------------------------------
// dm_cache_main_mem
//
// Backing-store model and controller sitting directly below the direct-mapped
// cache FSM. It accepts one line-sized (128-bit) read or write request at a time.
// After a programmable latency it returns the line data with a one-cycle ready
// strobe. It also keeps wrapping 32-bit counters of completed reads and writes.
//
// Ports
//   clk       in   1    clock; all state updates on posedge
//   rst       in   1    synchronous reset, active-low
//   mem_req   in   166  request bundle:
//                         [165:162] reserved (ignored)
//                         [161:130] addr
//                         [129:2]   data (write data)
//                         [1]       rw   (1 = write)
//                         [0]       valid
//   mem_data  out  129  response bundle: [128:1] data, [0] ready
//   busy      out  1    high while a request is counting down (BUSY state)
//   rd_count  out  32   completed reads, wraps at 2^32
//   wr_count  out  32   completed writes, wraps at 2^32
//
// Timing: a valid sampled at edge N puts the ready strobe on the cycle that
// ends at edge N+LAT. The array access itself happens on the edge that enters
// RESP. A read therefore returns the contents as of that edge. A write echoes
// the line it just stored.
// -----------------------------------------------------------------------------
module dm_cache_main_mem #(
    parameter int MEM_LINES     = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [165:0] mem_req,
    output logic [128:0] mem_data,
    output logic         busy,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int         IDX_W  = $clog2(MEM_LINES);
    localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
    localparam logic [7:0] WR_LAT = 8'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ---------------------------------------------------------------- request
    logic             w_req_valid;
    logic             w_req_rw;
    logic [127:0]     w_req_data;
    logic [31:0]      w_req_addr;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_unused_bits;

    assign w_req_valid = mem_req[0];
    assign w_req_rw    = mem_req[1];
    assign w_req_data  = mem_req[129:2];
    assign w_req_addr  = mem_req[161:130];
    // Upper address bits are dropped, so out-of-range addresses alias onto the array.
    assign w_req_idx   = w_req_addr[4 +: IDX_W];
    // Byte-in-line offset, aliasing bits and reserved bits carry no meaning here.
    assign w_unused_bits = ^{mem_req[165:162], w_req_addr[3:0], w_req_addr[31:4+IDX_W]};

    // ------------------------------------------------------------------ state
    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_cnt;
    logic             r_rw;
    logic [IDX_W-1:0] r_idx;
    logic [127:0]     r_wdata;
    logic [127:0]     r_rdata;
    logic [31:0]      r_rd_count;
    logic [31:0]      r_wr_count;

    logic [127:0]     r_mem [MEM_LINES];

    logic             w_accept;
    logic [7:0]       w_lat;
    logic             w_exec_now;
    logic             w_exec_busy;
    logic             w_exec;
    logic             w_exec_rw;
    logic [IDX_W-1:0] w_exec_idx;
    logic [127:0]     w_exec_data;

    // A request is accepted in IDLE or RESP. The RESP case gives back-to-back
    // write-back -> allocate service with no idle gap.
    assign w_accept = w_req_valid && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    assign w_lat    = w_req_rw ? WR_LAT : RD_LAT;

    // With a latency of one, the access happens on the accepting edge and uses
    // the live request fields. Otherwise it uses the latched copies on the last
    // BUSY edge.
    assign w_exec_now  = w_accept && (w_lat == 8'd1);
    assign w_exec_busy = (r_state == ST_BUSY) && (r_cnt <= 8'd1);
    assign w_exec      = w_exec_now || w_exec_busy;
    assign w_exec_rw   = w_exec_now ? w_req_rw   : r_rw;
    assign w_exec_idx  = w_exec_now ? w_req_idx  : r_idx;
    assign w_exec_data = w_exec_now ? w_req_data : r_wdata;

    // ------------------------------------------------------- FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------- FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_next = (w_lat == 8'd1) ? ST_RESP : ST_BUSY;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_exec_busy) begin
                    w_state_next = ST_RESP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- FSM: outputs
    always_comb begin
        busy     = (r_state == ST_BUSY);
        mem_data = {r_rdata, (r_state == ST_RESP)};
        rd_count = r_rd_count;
        wr_count = r_wr_count;
    end

    // ------------------------------------------------ request latch / countdown
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= w_lat - 8'd1;
            r_rw    <= w_req_rw;
            r_idx   <= w_req_idx;
            r_wdata <= w_req_data;
        end else if ((r_state == ST_BUSY) && (r_cnt != 8'd0)) begin
            r_cnt   <= r_cnt - 8'd1;
        end
    end

    // ------------------------------------------------------------- line array
    // Contents are never reset. They rely on the all-zero power-up image.
    // Reset blocks the write, so a reset in flight cannot corrupt a line.
    always_ff @(posedge clk) begin
        if (rst && w_exec && w_exec_rw) begin
            r_mem[w_exec_idx] <= w_exec_data;
        end
    end

    // The response data register holds its value until the next completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_exec) begin
            r_rdata <= w_exec_rw ? w_exec_data : r_mem[w_exec_idx];
        end
    end

    // ------------------------------------------------------ service counters
    // r_rw still names the completing request during RESP. A request accepted
    // on that same edge overwrites r_rw only after this edge has used it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else if (r_state == ST_RESP) begin
            if (r_rw) begin
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_rd_count <= r_rd_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_main_mem.sv
module tb_dm_cache_main_mem;

    localparam int MEM_LINES = 4096;
    localparam int RL        = 4;
    localparam int WL        = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [165:0] mem_req = '0;
    logic [128:0] mem_data;
    logic         busy;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    dm_cache_main_mem #(
        .MEM_LINES    (MEM_LINES),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_req (mem_req),
        .mem_data(mem_data),
        .busy    (busy),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: flat line array plus expected counters and last response.
    bit [127:0]  model_mem [MEM_LINES];
    int unsigned exp_rd   = 0;
    int unsigned exp_wr   = 0;
    logic [127:0] exp_data = '0;
    logic [165:0] chain_req = '0;

    function automatic logic [165:0] pack(input logic [31:0] addr, input logic [127:0] data,
                                          input logic rw, input logic valid);
        return {4'b0000, addr, data, rw, valid};
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr / 32'd16) % MEM_LINES);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request and follow it to its ready strobe.
    // pre_driven: the request is already on mem_req (driven in a prior RESP cycle).
    // chain: drive chain_req in the RESP cycle instead of dropping valid.
    // noise: drive junk valid requests during BUSY, which must be ignored.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [127:0] wdata,
                           input logic rw, input bit noise, input bit pre_driven, input bit chain);
        int lat;
        int waited;
        bit seen;
        int idx;
        lat    = rw ? WL : RL;
        waited = 0;
        seen   = 0;
        idx    = line_of(addr);
        if (!pre_driven) begin
            @(negedge clk);
            mem_req = pack(addr, wdata, rw, 1'b1);
        end
        @(posedge clk);
        while (!seen && waited < lat + 8) begin
            @(negedge clk);
            waited++;
            if (mem_data[0] === 1'b1) begin
                seen = 1;
                if (rw) begin
                    model_mem[idx] = wdata;
                    exp_data = wdata;
                    exp_wr++;
                end else begin
                    exp_data = model_mem[idx];
                    exp_rd++;
                end
                checks++;
                if (waited !== lat) begin
                    failures++;
                    $display("FAIL %s latency: got %0d cycles, expected %0d", name, waited, lat);
                end
                checks++;
                if (mem_data[128:1] !== exp_data) begin
                    failures++;
                    $display("FAIL %s data: got %h, expected %h", name, mem_data[128:1], exp_data);
                end
                mem_req = chain ? chain_req : '0;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_wait: got %b, expected 1 at cycle %0d", name, busy, waited);
                end
                if (noise) begin
                    mem_req = pack($urandom, rand128(), 1'($urandom_range(0, 1)), 1'b1);
                end else begin
                    mem_req = '0;
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no ready within %0d cycles, expected %0d", name, waited, lat);
            mem_req = '0;
        end else if (!chain) begin
            @(negedge clk);
            checks++;
            if (mem_data[0] !== 1'b0) begin
                failures++;
                $display("FAIL %s ready_pulse: got ready=%b after strobe, expected 0", name, mem_data[0]);
            end
            checks++;
            if (mem_data[128:1] !== exp_data) begin
                failures++;
                $display("FAIL %s data_hold: got %h, expected %h", name, mem_data[128:1], exp_data);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_after: got %b, expected 0", name, busy);
            end
            checks++;
            if (rd_count !== exp_rd || wr_count !== exp_wr) begin
                failures++;
                $display("FAIL %s counters: got rd=%0d wr=%0d, expected rd=%0d wr=%0d",
                         name, rd_count, wr_count, exp_rd, exp_wr);
            end
        end
        $display("txn %s addr=%h rw=%0d line=%0d cycles=%0d data=%h", name, addr, rw, idx, waited,
                 mem_data[128:1]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        exp_rd = 0;
        exp_wr = 0;
        exp_data = '0;
        checks++;
        if (mem_data[0] !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b, expected 0", mem_data[0]); end
        checks++;
        if (mem_data[128:1] !== 128'h0) begin failures++; $display("FAIL reset_data: got %h, expected 0", mem_data[128:1]); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (rd_count !== 32'd0) begin failures++; $display("FAIL reset_rd_count: got %0d, expected 0", rd_count); end
        checks++;
        if (wr_count !== 32'd0) begin failures++; $display("FAIL reset_wr_count: got %0d, expected 0", wr_count); end
        $display("txn reset done");
    endtask

    task automatic test_read_zero();
        run_txn("read_zero", 32'h0000_0010, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_read();
        run_txn("write_40", 32'h0000_0040, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0,
                1'b1, 1'b0, 1'b0, 1'b0);
        run_txn("read_40", 32'h0000_0040, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        d = rand128();
        chain_req = pack(32'h0000_0040, d, 1'b1, 1'b1);
        run_txn("b2b_read", 32'h0000_0080, 128'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_txn("b2b_write", 32'h0000_0040, d, 1'b1, 1'b0, 1'b1, 1'b0);
        run_txn("b2b_check", 32'h0000_0040, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignored();
        run_txn("noise_read", 32'h0000_0040, 128'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn("noise_write", 32'h0000_0050, rand128(), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_alias();
        run_txn("alias_write", (32'(MEM_LINES) << 4) + 32'h40, rand128(), 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn("alias_read", 32'h0000_0040, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        bit strobe_seen;
        // Reset lands two cycles after acceptance, before the write executes.
        @(negedge clk);
        mem_req = pack(32'h0000_0040, rand128(), 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        mem_req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        exp_data = '0;
        strobe_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_data[0] === 1'b1) strobe_seen = 1;
        end
        checks++;
        if (strobe_seen) begin failures++; $display("FAIL rstmid_ready: got a ready strobe, expected none"); end
        checks++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_counters: got rd=%0d wr=%0d, expected 0 0", rd_count, wr_count);
        end
        checks++;
        if (mem_data[128:1] !== 128'h0) begin failures++; $display("FAIL rstmid_data: got %h, expected 0", mem_data[128:1]); end
        $display("txn reset_mid_write done");
        run_txn("rstmid_readback", 32'h0000_0040, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset and an accepting valid on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b0;
        mem_req = pack(32'h0000_0080, rand128(), 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        mem_req = '0;
        exp_rd = 0;
        exp_wr = 0;
        exp_data = '0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstprio_busy: got %b, expected 0", busy); end
        strobe_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_data[0] === 1'b1) strobe_seen = 1;
        end
        checks++;
        if (strobe_seen) begin failures++; $display("FAIL rstprio_ready: got a ready strobe, expected none"); end
        $display("txn reset_priority done");
        run_txn("rstprio_readback", 32'h0000_0080, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            // Small line set with random upper bits, so that reads hit written and aliased lines.
            a = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            a[31:4+$clog2(MEM_LINES)] = 12'($urandom);
            run_txn("rand", a, rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_back_to_back();
        test_busy_ignored();
        test_alias();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
